alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute-stage ALU that consumes the 3-bit alucontrol code produced by the ALU decoder.
//  Logic, add/sub, slt and compare ops complete in one cycle. mult (3'b011) runs as an
//  iterative unsigned shift-add over n cycles, with busy stalling the pipeline.
//  Results are registered, and a done pulse marks each completion.
// PARAMETERS
//  n   32   operand/result width in bits (>=2)
// PORTS
//  clk         in   1    rising-edge clock
//  reset_n     in   1    asynchronous, active-low reset
//  start       in   1    op request; accepted only when busy=0
//  alucontrol  in   3    op code from ALU decoder, sampled at accept
//  a           in   n    operand A, sampled at accept
//  b           in   n    operand B, sampled at accept
//  result      out  n    registered result (low n bits for mult)
//  hi          out  n    upper n bits of the last mult product
//  zero        out  1    branch/zero flag, registered with result
//  busy        out  1    1 while a mult is iterating; start ignored
//  done        out  1    one-cycle pulse: result/hi/zero just updated
// BEHAVIOUR
//  Interface: one clock, clk; reset_n is asynchronous and active-low, and the block is
//   entirely synchronous to clk otherwise.
//  Reset: state=IDLE; result=0, hi=0, zero=0, busy=0, done=0; count=0.
//   Asserting reset mid-mult aborts it: no done, and partial products are discarded.
//  Accept: at a rising edge with start=1 & busy=0, alucontrol, a and b are captured.
//   With start=1 & busy=1, the request is ignored (dropped, not queued).
//  Single-cycle ops (latency 1):
//   - result is written at the accept edge, and done=1 for the following cycle.
//   000 and: a&b | 001 or: a|b | 100 nor: ~(a|b)
//   010 add: a+b, mod 2^n, no overflow flag
//   110 sub/beq: a-b mod 2^n; zero = (a==b)
//   101 bne: result = a-b; zero = (a!=b)
//   111 slt: result = {(n-1)'b0, $signed(a)<$signed(b)}
//   zero for 000/001/010/100/111 = (result==0). hi is unchanged by non-mult ops.
//  mult (011), FSM IDLE -> MUL -> IDLE:
//   - Accept edge k: load mcand=a, mplier=b, acc=0 (2n bits), count=0;
//     state=MUL and busy=1.
//   - Edges k+1..k+n: if mplier[0], acc += mcand<<count; then shift mplier right
//     and increment count.
//   - Edge k+n (count reaches n): {hi,result} = acc, zero = (acc[n-1:0]==0),
//     state=IDLE, busy=0, done=1.
//   - busy is therefore high for exactly n cycles, and done follows at latency n.
//   - Unsigned product only; 2n-bit product, no truncation except the split into hi/result.
//  done cycle: busy=0, so a new start in that cycle is accepted (back-to-back ops).
//  done is never high two consecutive cycles for one op. Back-to-back single-cycle ops
//   give done high on consecutive cycles, one pulse per op.
//  Outputs hold their value between completions. Inputs are don't-care when not accepting.
// TESTING
//  1 add: start, 010, a=5, b=7 -> next cycle result=12, zero=0, done=1 for 1 cycle, busy=0.
//  2 branch: a=b=9 with 110 -> result=0, zero=1; same operands with 101 -> result=0, zero=0.
//  3 slt/nor: 111, a=32'hFFFFFFFF, b=1 -> result=1; 100, a=0, b=0 -> result=32'hFFFFFFFF,
//    zero=0.
//  4 mult: 011, a=32'hFFFFFFFF, b=2 -> busy=1 for 32 cycles, then result=32'hFFFFFFFE,
//    hi=1, done=1. A start (010, 1, 1) issued mid-mult is ignored.
//  5 reset mid-mult: reset_n=0 at iteration 10 -> outputs immediately 0, no done.
//    Then 3*4 -> hi=0, result=12.
//  6 back-to-back: start held with a new add in the done cycle of a mult -> add accepted.
//    done pulses on 2 consecutive cycles; hi still holds the mult upper half.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU: logic/add/sub/slt/branch ops in 1 cycle, unsigned mult in n cycles.
// Backpressure: busy is high while a mult iterates; start is dropped, not queued, during that time.
module alu_exec #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [2:0]   alucontrol,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] result,
   output logic [n-1:0] hi,
   output logic         zero,
   output logic         busy,
   output logic         done
);

   localparam int cw = $clog2(n + 1);

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last;
   logic [2*n-1:0]   mcand;
   logic [2*n-1:0]   acc;
   logic [2*n-1:0]   acc_nxt;
   logic [n-1:0]     mplier;
   logic [cw-1:0]    count;
   logic [n-1:0]     alu_res;
   logic             alu_zero;
   logic             lt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = start && (state == IDLE);
      last      = (state == MUL) && (count == cw'(n - 1));
      acc_nxt   = acc + (mplier[0] ? mcand : '0);
      case (state)
         IDLE:    if (accept && alucontrol == 3'b011) state_nxt = MUL;
         MUL:     if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_res  = '0;
      alu_zero = 1'b0;
      lt       = $signed(a) < $signed(b);
      case (alucontrol)
         3'b000:  alu_res = a & b;
         3'b001:  alu_res = a | b;
         3'b100:  alu_res = ~(a | b);
         3'b010:  alu_res = a + b;
         3'b110:  alu_res = a - b;
         3'b101:  alu_res = a - b;
         3'b111:  alu_res = {{(n-1){1'b0}}, lt};
         default: alu_res = '0;
      endcase
      case (alucontrol)
         3'b110:  alu_zero = (a == b);
         3'b101:  alu_zero = (a != b);
         default: alu_zero = (alu_res == '0);
      endcase
   end

   // Multiplicand is shifted in place, equivalent to adding mcand<<count each step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result <= '0;
         hi     <= '0;
         zero   <= 1'b0;
         done   <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (alucontrol == 3'b011) begin
               mcand  <= {{n{1'b0}}, a};
               mplier <= b;
               acc    <= '0;
               count  <= '0;
            end else begin
               result <= alu_res;
               zero   <= alu_zero;
               done   <= 1'b1;
            end
         end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + cw'(1);
            if (last) begin
               {hi, result} <= acc_nxt;
               zero         <= (acc_nxt[n-1:0] == '0);
               done         <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == MUL);

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [2:0]   alucontrol;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] result;
   logic [N-1:0] hi;
   logic         zero;
   logic         busy;
   logic         done;

   typedef struct packed {
      logic [N-1:0] res;
      logic [N-1:0] hi;
      logic         z;
   } exp_t;

   exp_t         q[$];
   int           total = 0;
   int           bad = 0;
   logic [N-1:0] model_hi = '0;

   alu_exec #(.n(N)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .alucontrol(alucontrol),
      .a(a), .b(b), .result(result), .hi(hi), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Scoreboard: every done pulse pops one expected completion.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1 && done === 1'b1) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done t=%0t result=%h hi=%h zero=%b required no done", $time, result, hi, zero);
         end else begin
            e = q.pop_front();
            if ({result, hi, zero} !== {e.res, e.hi, e.z}) begin
               bad++;
               $display("FAIL completion t=%0t got result=%h hi=%h zero=%b required result=%h hi=%h zero=%b",
                        $time, result, hi, zero, e.res, e.hi, e.z);
            end
         end
      end
   end

   function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t           e;
      logic [2*N-1:0] p;
      e.hi = model_hi;
      e.res = '0;
      case (op)
         3'b000: e.res = x & y;
         3'b001: e.res = x | y;
         3'b100: e.res = ~(x | y);
         3'b010: e.res = x + y;
         3'b110: e.res = x - y;
         3'b101: e.res = x - y;
         3'b111: e.res = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
         default: begin
            p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
            e.res = p[N-1:0];
            e.hi = p[2*N-1:N];
         end
      endcase
      if (op == 3'b110) e.z = (x == y);
      else if (op == 3'b101) e.z = (x != y);
      else e.z = (e.res == '0);
      return e;
   endfunction

   // Drive one request for the accept edge; returns at accept edge + 1.
   task automatic issue(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t e;
      e = model(op, x, y);
      if (op == 3'b011) model_hi = e.hi;
      q.push_back(e);
      start = 1'b1; alucontrol = op; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; alucontrol = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({result, hi, zero, busy, done} !== {{(2*N){1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL reset_state got result=%h hi=%h zero=%b busy=%b done=%b required all zero", result, hi, zero, busy, done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      issue(3'b010, 32'd5, 32'd7);
      total++;
      if ({result, zero, done, busy} !== {32'd12, 3'b010}) begin
         bad++;
         $display("FAIL add got result=%0d zero=%b done=%b busy=%b required 12 0 1 0", result, zero, done, busy);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL add_done_pulse got done=%b required 0", done);
      end
   endtask

   task automatic test_branch;
      issue(3'b110, 32'd9, 32'd9);
      total++;
      if ({result, zero} !== {32'd0, 1'b1}) begin
         bad++;
         $display("FAIL beq got result=%h zero=%b required 0 1", result, zero);
      end
      issue(3'b101, 32'd9, 32'd9);
      total++;
      if ({result, zero, done} !== {32'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL bne got result=%h zero=%b done=%b required 0 0 1", result, zero, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_slt_nor;
      issue(3'b111, 32'hFFFFFFFF, 32'd1);
      total++;
      if (result !== 32'd1) begin
         bad++;
         $display("FAIL slt_neg got result=%h required 1", result);
      end
      issue(3'b111, 32'd1, 32'hFFFFFFFF);
      total++;
      if ({result, zero} !== {32'd0, 1'b1}) begin
         bad++;
         $display("FAIL slt_pos got result=%h zero=%b required 0 1", result, zero);
      end
      issue(3'b100, 32'd0, 32'd0);
      total++;
      if ({result, zero} !== {32'hFFFFFFFF, 1'b0}) begin
         bad++;
         $display("FAIL nor got result=%h zero=%b required ffffffff 0", result, zero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random_ops;
      logic [2:0] ops [7];
      ops = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b110, 3'b101, 3'b111};
      for (int i = 0; i < 14; i++) begin
         issue(ops[i % 7], $urandom, (i % 3 == 0) ? 32'hFFFFFFFF : $urandom);
      end
      issue(3'b010, 32'hFFFFFFFF, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic test_mult;
      int cyc;
      issue(3'b011, 32'hFFFFFFFF, 32'd2);
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         if (cyc == 10) begin
            start = 1'b1; alucontrol = 3'b010; a = 32'd1; b = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      total++;
      if (cyc != N) begin
         bad++;
         $display("FAIL mult_busy_cycles got %0d required %0d", cyc, N);
      end
      total++;
      if ({result, hi, done} !== {32'hFFFFFFFE, 32'd1, 1'b1}) begin
         bad++;
         $display("FAIL mult got result=%h hi=%h done=%b required fffffffe 1 1", result, hi, done);
      end
      repeat (4) @(posedge clk);
      #1;
      issue(3'b011, $urandom, $urandom);
      wait_idle(100, cyc);
      issue(3'b011, 32'd0, $urandom);
      wait_idle(100, cyc);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_mult;
      int cyc;
      int dones;
      issue(3'b011, 32'h12345678, 32'h9ABCDEF0);
      repeat (9) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if ({result, hi, zero, busy, done} !== {{(2*N){1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL reset_mid_mult got result=%h hi=%h zero=%b busy=%b done=%b required all zero", result, hi, zero, busy, done);
      end
      q.delete();
      model_hi = '0;
      @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL aborted_mult_done got %0d pulses required 0", dones);
      end
      issue(3'b011, 32'd3, 32'd4);
      wait_idle(100, cyc);
      total++;
      if ({hi, result, done} !== {32'd0, 32'd12, 1'b1}) begin
         bad++;
         $display("FAIL mult_after_reset got hi=%h result=%h done=%b required 0 c 1", hi, result, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int       cyc;
      exp_t     e;
      logic [N-1:0] mhi;
      issue(3'b011, 32'hDEADBEEF, 32'h00010001);
      mhi = model_hi;
      e = model(3'b010, 32'd20, 32'd22);
      q.push_back(e);
      start = 1'b1; alucontrol = 3'b010; a = 32'd20; b = 32'd22;
      wait_idle(100, cyc);
      total++;
      if ({done, busy} !== 2'b10) begin
         bad++;
         $display("FAIL b2b_mult_done got done=%b busy=%b required 1 0", done, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if ({done, result, hi} !== {1'b1, 32'd42, mhi}) begin
         bad++;
         $display("FAIL b2b_add got done=%b result=%0d hi=%h required 1 42 %h", done, result, hi, mhi);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_done_end got done=%b required 0", done);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_slt_nor();
      test_random_ops();
      test_mult();
      test_reset_mid_mult();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_completions got %0d required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
